// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Bundles the keypad pins and the key-event outputs of keypad_scanner.
//   row_in    : keypad rows, active-low, asynchronous to the system clock
//   col_out   : one-hot active-low column drive
//   key_press : one-cycle strobe for an accepted key
//   item_code : code of the last accepted key, held between presses
//   bad_key   : one-cycle strobe for a rejected non-digit key
// Modports: master = the scanner itself, slave = keypad side / consumer.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_press;
  logic [3:0] item_code;
  logic       bad_key;

  modport master (
    input  row_in,
    output col_out,
    output key_press,
    output item_code,
    output bad_key
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_press,
    input  item_code,
    input  bad_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low keypad one column at a time, debounces press and
// release, and emits one key event per physical key press.
// Ports:
//   clock : system clock, rising edge
//   rst   : synchronous active-high reset
//   kp    : keypad_scanner_if.master (row_in in; col_out, key_press,
//           item_code, bad_key out; all outputs registered)
// Parameters:
//   SCAN_DIV : cycles each column is driven (>= 4, covers synchronizer delay)
//   DEBOUNCE : consecutive stable cycles required for press and for release
// Build option:
//   KEYPAD_DIGIT_ONLY_EN : when defined, codes 10-15 pulse bad_key instead of
//   key_press and leave item_code untouched; when undefined bad_key stays 0.
module keypad_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 8
) (
  input  logic             clock,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Lowest-index low row wins when several rows are pressed together.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0]    row_meta_r, row_sync_r;
  state_t        state_r, state_s;
  logic [DW-1:0] div_r, div_s;
  logic [1:0]    col_r, col_s;
  logic [1:0]    row_idx_r, row_idx_s;
  logic [SW-1:0] stab_r, stab_s;
  logic [3:0]    col_out_r, col_out_s;
  logic          key_press_r, key_press_s;
  logic [3:0]    item_code_r, item_code_s;
  logic          bad_key_r, bad_key_s;
  logic          accept_s;

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge clock) begin
    if (rst) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
    end else begin
      row_meta_r <= kp.row_in;
      row_sync_r <= row_meta_r;
    end
  end

  // Next-state, datapath and event decode for the scan/debounce FSM.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    col_s       = col_r;
    row_idx_s   = row_idx_r;
    stab_s      = stab_r;
    key_press_s = 1'b0;
    bad_key_s   = 1'b0;
    item_code_s = item_code_r;
`ifdef KEYPAD_DIGIT_ONLY_EN
    accept_s = ({row_idx_r, col_r} <= 4'd9);
`else
    accept_s = 1'b1;
`endif
    case (state_r)
      ST_SCAN: begin
        // Rows are only sampled at the end of a slot, after the synchronizer
        // has caught up with the column change.
        if (div_r == DIV_LAST) begin
          if (row_sync_r != 4'b1111) begin
            row_idx_s = lowest_row(row_sync_r);
            stab_s    = {SW{1'b0}};
            state_s   = ST_DEBOUNCE;
          end else begin
            col_s = col_r + 2'd1;
            div_s = {DW{1'b0}};
          end
        end else begin
          div_s = div_r + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      ST_DEBOUNCE: begin
        if (!row_sync_r[row_idx_r]) begin
          stab_s = stab_r + {{(SW-1){1'b0}}, 1'b1};
          if (stab_r == STAB_LAST) begin
            state_s = ST_PRESSED;
          end else begin
            state_s = ST_DEBOUNCE;
          end
        end else begin
          // Contact bounced open: give up on this key and move on.
          state_s = ST_SCAN;
          col_s   = col_r + 2'd1;
          div_s   = {DW{1'b0}};
        end
      end
      ST_PRESSED: begin
        if (accept_s) begin
          key_press_s = 1'b1;
          item_code_s = {row_idx_r, col_r};
        end else begin
          bad_key_s = 1'b1;
        end
        stab_s  = {SW{1'b0}};
        state_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Any low row (held key or a second key) restarts the release count.
        if (row_sync_r == 4'b1111) begin
          stab_s = stab_r + {{(SW-1){1'b0}}, 1'b1};
          if (stab_r == STAB_LAST) begin
            state_s = ST_SCAN;
            col_s   = col_r + 2'd1;
            div_s   = {DW{1'b0}};
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          stab_s = {SW{1'b0}};
        end
      end
      default: begin
        state_s = ST_SCAN;
        div_s   = {DW{1'b0}};
        col_s   = 2'd0;
      end
    endcase
    col_out_s = ~(4'b0001 << col_s);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r     <= ST_SCAN;
      div_r       <= {DW{1'b0}};
      col_r       <= 2'd0;
      row_idx_r   <= 2'd0;
      stab_r      <= {SW{1'b0}};
      col_out_r   <= 4'b1110;
      key_press_r <= 1'b0;
      item_code_r <= 4'h0;
      bad_key_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      col_r       <= col_s;
      row_idx_r   <= row_idx_s;
      stab_r      <= stab_s;
      col_out_r   <= col_out_s;
      key_press_r <= key_press_s;
      item_code_r <= item_code_s;
      bad_key_r   <= bad_key_s;
    end
  end

  assign kp.col_out   = col_out_r;
  assign kp.key_press = key_press_r;
  assign kp.item_code = item_code_r;
  assign kp.bad_key   = bad_key_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3. A keypad
// model pulls a row low only while its key is held and its column is driven.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        rst;
  logic [15:0] held;
  logic [3:0]  rows_s;
  logic [3:0]  exp_col;
  int          total = 0;
  int          bad = 0;
  int          press_cnt = 0;
  int          bad_cnt = 0;
  int          both_cnt = 0;
  int          base_p;
  int          base_b;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .kp    (kp)
  );

  always #5 clock = ~clock;

  // Keypad model: key index = row*4 + col.
  always_comb begin
    rows_s = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[r*4+c] && (kp.col_out[c] == 1'b0)) begin
          rows_s[r] = 1'b0;
        end
      end
    end
  end
  assign kp.row_in = rows_s;

  // Strobe counters.
  always @(posedge clock) begin
    if (kp.key_press === 1'b1) press_cnt <= press_cnt + 1;
    if (kp.bad_key === 1'b1) bad_cnt <= bad_cnt + 1;
    if ((kp.key_press === 1'b1) && (kp.bad_key === 1'b1)) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic wait_col(input logic [3:0] col, input int budget);
    for (int i = 0; (i < budget) && (kp.col_out !== col); i++) @(negedge clock);
  endtask

  task automatic wait_col_not(input logic [3:0] col, input int budget);
    for (int i = 0; (i < budget) && (kp.col_out === col); i++) @(negedge clock);
  endtask

  task automatic wait_event(input int budget);
    int start;
    start = press_cnt + bad_cnt;
    for (int i = 0; (i < budget) && ((press_cnt + bad_cnt) == start); i++) @(negedge clock);
  endtask

  initial begin
    rst  = 1'b1;
    held = 16'h0000;
    repeat (3) @(negedge clock);
    rst = 1'b0;

    // Reset values and idle scan sequence (one column per 4 cycles).
    check("rst_key_press", 32'(kp.key_press), 32'd0);
    check("rst_item_code", 32'(kp.item_code), 32'd0);
    check("rst_bad_key", 32'(kp.bad_key), 32'd0);
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clock);
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      check("idle_col", 32'(kp.col_out), 32'(exp_col));
    end

    // Hold row1/col2 for 40 cycles, then release.
    base_p = press_cnt;
    base_b = bad_cnt;
    held = 16'h0040;
    repeat (40) @(negedge clock);
    check("s1_press_count", 32'(press_cnt - base_p), 32'd1);
    check("s1_item_code", 32'(kp.item_code), 32'h6);
    held = 16'h0000;
    wait_col_not(4'b1011, 30);
    check("s1_resume_col3", 32'(kp.col_out), 32'(4'b0111));
    repeat (30) @(negedge clock);
    check("s1_no_refire", 32'(press_cnt - base_p), 32'd1);
    check("s1_no_bad", 32'(bad_cnt - base_b), 32'd0);

    // Bounce on row0/col1: 2 low, 1 high, then held.
    wait_col(4'b1110, 40);
    wait_col(4'b1101, 40);
    base_p = press_cnt;
    held = 16'h0002;
    repeat (2) @(negedge clock);
    held = 16'h0000;
    @(negedge clock);
    held = 16'h0002;
    repeat (5) @(negedge clock);
    check("s2_bounce_no_strobe", 32'(press_cnt - base_p), 32'd0);
    check("s2_bounce_abort_col", 32'(kp.col_out), 32'(4'b1011));
    wait_event(80);
    held = 16'h0000;
    repeat (30) @(negedge clock);
    check("s2_press_count", 32'(press_cnt - base_p), 32'd1);
    check("s2_item_code", 32'(kp.item_code), 32'h1);

    // Rows 0 and 2 together in column 3: lowest row wins.
    base_p = press_cnt;
    held = 16'h0808;
    wait_event(80);
    held = 16'h0000;
    repeat (30) @(negedge clock);
    check("s3_press_count", 32'(press_cnt - base_p), 32'd1);
    check("s3_item_code", 32'(kp.item_code), 32'h3);

    // Non-digit key row3/col0 (code 12).
    base_p = press_cnt;
    base_b = bad_cnt;
    held = 16'h1000;
    wait_event(80);
    held = 16'h0000;
    repeat (30) @(negedge clock);
`ifdef KEYPAD_DIGIT_ONLY_EN
    check("s4_bad_count", 32'(bad_cnt - base_b), 32'd1);
    check("s4_press_count", 32'(press_cnt - base_p), 32'd0);
    check("s4_item_code", 32'(kp.item_code), 32'h3);
`else
    check("s4_press_count", 32'(press_cnt - base_p), 32'd1);
    check("s4_bad_count", 32'(bad_cnt - base_b), 32'd0);
    check("s4_item_code", 32'(kp.item_code), 32'hC);
`endif

    // Reset during the debounce of key 5, then re-detect it.
    wait_col(4'b0111, 40);
    held = 16'h0020;
    wait_col(4'b1101, 40);
    base_p = press_cnt;
    repeat (5) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    check("s5_col_after_rst", 32'(kp.col_out), 32'(4'b1110));
    check("s5_key_press_after_rst", 32'(kp.key_press), 32'd0);
    check("s5_item_code_after_rst", 32'(kp.item_code), 32'h0);
    repeat (3) @(negedge clock);
    check("s5_dropped_event", 32'(press_cnt - base_p), 32'd0);
    check("s5_col_still_0", 32'(kp.col_out), 32'(4'b1110));
    wait_event(80);
    held = 16'h0000;
    repeat (30) @(negedge clock);
    check("s5_press_count", 32'(press_cnt - base_p), 32'd1);
    check("s5_item_code", 32'(kp.item_code), 32'h5);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
